uart_tx: RTL

- 8N1 UART transmitter: serialises one byte per frame onto `out` as start bit, 8 data bits LSB first, and stop bit.
- Each bit is held for Oversample clock cycles, matching the bit timing the receiver expects at the same Oversample and clock.
- Sits between a byte-producing client (valid/ready handshake) and the serial line; line idles high.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_bit_timer.sv | 29 ++
 rtl/uart_tx.sv | 96 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam int DataBits = 8;

    // Width of the per-bit sample down counter; kept at least one bit wide
    function automatic int cnt_width(input int oversample);
        return (oversample < 2) ? 1 : $clog2(oversample);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit down counter that ticks on the last cycle of a bit
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int Oversample = 16
) (
    input  logic clk,
    input  logic nReset,
    input  logic reload,
    output logic tick
);

    localparam int W = cnt_width(Oversample);
    localparam logic [W-1:0] CountTop = W'(Oversample - 1);

    logic [W-1:0] count;

    assign tick = (count == '0);

    // Count down through a bit; restart at every bit boundary or when held by reload
    always_ff @(posedge clk) begin
        if (!nReset || reload || tick) begin
            count <= CountTop;
        end else begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with valid/ready byte input
module uart_tx
    import uart_pkg::*;
#(
    parameter int Oversample = 16
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       out,
    output logic       busy,
    output logic       done
);

    uart_tx_state_t        state;
    logic [DataBits-1:0]   shreg;
    logic [2:0]            bit_cnt;
    logic                  tick;
    logic                  reload;
    logic                  accept;

    // The timer is held at its top value while idle, so START always begins a full bit
    assign reload = (state == IDLE);
    assign ready  = (state == IDLE) || ((state == STOP) && tick);
    assign accept = valid && ready;
    assign busy   = (state != IDLE);
    assign done   = (state == STOP) && tick;

    uart_bit_timer #(
        .Oversample(Oversample)
    ) u_bit_timer (
        .clk   (clk),
        .nReset(nReset),
        .reload(reload),
        .tick  (tick)
    );

    // Frame sequencer; out is computed one cycle ahead so it comes straight from a flop
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            out     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    out <= 1'b1;
                    if (accept) begin
                        shreg <= data;
                        state <= START;
                        out   <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        out     <= shreg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= shreg >> 1;
                        if (bit_cnt == 3'(DataBits - 1)) begin
                            state <= STOP;
                            out   <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            out     <= shreg[1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (accept) begin
                            shreg <= data;
                            state <= START;
                            out   <= 1'b0;
                        end else begin
                            state <= IDLE;
                            out   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= 1'b1;
                end
            endcase
        end
    end

endmodule
